program_loader: RTL and testbench

- Write-side counterpart of the CPU's 16x8 program memory.
- Accepts a byte stream from an external host using a valid/ready handshake. The first byte is a length, followed by that many program bytes.
- Writes the program bytes into RAM from address 0 upward, while holding the CPU in halt.
- Sits between the host link (UART/switch-panel front end) and the memory's write port.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/program_loader.sv | 148 ++++++++++++++
 tb/tb_program_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader state encoding and default bus widths.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    // A length byte of zero requests a full-memory load.
    localparam bit LEN_ZERO_MEANS_DEPTH = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CSUM,
        FINISH
    } state_e;

endpackage

// File: rtl/program_loader.sv
// Streams a length-prefixed program from the host into program RAM, holding the CPU in halt.
// Optional trailing checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_LAST = CSUM;
`else
    localparam state_e AFTER_LAST = FINISH;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              error_q, error_d;
    logic              accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    assign in_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign accept   = in_valid && in_ready;
    assign wr_en    = (state_q == WRITE);
    assign cpu_halt = (state_q != IDLE);
    assign busy     = cpu_halt;
    assign done     = (state_q == FINISH);
    assign error    = error_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        error_d   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    if (in_data == '0) begin
                        if (LEN_ZERO_MEANS_DEPTH) begin
                            count_d = CNT_W'(DEPTH);
                            state_d = DATA;
                        end else begin
                            state_d = FINISH;
                        end
                    end else if (in_data > DATA_W'(DEPTH)) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        count_d = CNT_W'(in_data);
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wr_data_d = in_data;
                    wr_addr_d = addr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q + in_data;
`endif
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 1'b1;
                state_d = (count_q == CNT_W'(1)) ? AFTER_LAST : DATA;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = FINISH;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            error_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            error_q   <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; checksum vectors are added when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_halt;
    logic       busy;
    logic       done;
    logic       error;

    program_loader #(
        .ADDR_W(4),
        .DATA_W(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cpu_halt(cpu_halt),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    logic [3:0] waddr_q[$];
    logic [7:0] wdata_q[$];
    int         wcyc_q[$];
    int         acyc_q[$];
    int n_done = 0, n_errp = 0, n_both = 0, n_rdy_wr = 0, n_halt_bad = 0;

    logic [7:0] pay[$];

    always @(posedge clk) cyc++;

    // Observed at the falling edge: an accept seen here lands on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                waddr_q.push_back(wr_addr);
                wdata_q.push_back(wr_data);
                wcyc_q.push_back(cyc);
            end
            if (in_valid && in_ready) acyc_q.push_back(cyc + 1);
            if (done) n_done++;
            if (error) n_errp++;
            if (done && error) n_both++;
            if (wr_en && in_ready) n_rdy_wr++;
            if (busy != cpu_halt) n_halt_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {14'b0, in_ready, wr_en, cpu_halt, busy, done, error, wr_addr, wr_data};
    endfunction

    function automatic logic [7:0] sum8();
        logic [7:0] s = 8'h00;
        foreach (pay[i]) s = s + pay[i];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 1'b0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", 32'(ok), 32'd1);
        tick();
        if (gaps) in_valid = 1'b0;
    endtask

    task automatic send_load(input logic [7:0] len, input bit gaps);
        send_byte(len, gaps);
        foreach (pay[i]) send_byte(pay[i], gaps);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(sum8(), gaps);
`endif
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int  base = n_done + n_errp;
        bit  ok   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (n_done + n_errp > base) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_end"}, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    int wb, ab, db, eb;

    initial begin
        do_reset();
        check("rst_outs", out_vec(), 32'h0);

        // Reset asserted asynchronously while waiting for the length byte.
        pulse_start();
        check("len_ready", 32'(in_ready), 32'd1);
        check("len_halt", 32'(cpu_halt), 32'd1);
        #2 rst = 1'b0;
        #1 check("rst_in_len", out_vec(), 32'h0);
        tick();
        rst = 1'b1;
        wb = wdata_q.size();
        pulse_start();
        repeat (5) tick();
        check("idle_host_ready", 32'(in_ready), 32'd1);
        check("idle_host_busy", 32'(busy), 32'd1);
        check("idle_host_nowr", 32'(wdata_q.size() - wb), 32'd0);
        do_reset();

        // Three-byte load with valid held high throughout.
        wb = wdata_q.size(); ab = acyc_q.size(); db = n_done; eb = n_errp;
        pay = '{8'hA1, 8'hB2, 8'hC3};
        pulse_start();
        send_load(8'h03, 1'b0);
        wait_end("t3");
        @(negedge clk);
        check("t3_halt_after", 32'(cpu_halt), 32'd0);
        check("t3_nwr", 32'(wdata_q.size() - wb), 32'd3);
        check("t3_a0", 32'(waddr_q[wb]), 32'h0);
        check("t3_a1", 32'(waddr_q[wb+1]), 32'h1);
        check("t3_a2", 32'(waddr_q[wb+2]), 32'h2);
        check("t3_d0", 32'(wdata_q[wb]), 32'hA1);
        check("t3_d1", 32'(wdata_q[wb+1]), 32'hB2);
        check("t3_d2", 32'(wdata_q[wb+2]), 32'hC3);
        for (int k = 0; k < 3; k++) check("t3_lat", 32'(wcyc_q[wb+k]), 32'(acyc_q[ab+1+k]));
        check("t3_rdy_in_wr", 32'(n_rdy_wr), 32'd0);
        check("t3_done", 32'(n_done - db), 32'd1);
        check("t3_err", 32'(n_errp - eb), 32'd0);

        // Asynchronous reset in DATA after a write: registered write bus clears.
        pulse_start();
        send_byte(8'h02, 1'b1);
        send_byte(8'h5E, 1'b1);
        tick();
        #2 rst = 1'b0;
        #1 check("rst_in_data", out_vec(), 32'h0);
        tick();
        rst = 1'b1;

        // Length 0 means a full 16-word load.
        wb = wdata_q.size(); db = n_done; eb = n_errp;
        pay = {};
        for (int k = 0; k < 16; k++) pay.push_back(8'(k));
        pulse_start();
        send_load(8'h00, 1'b0);
        wait_end("full");
        check("full_nwr", 32'(wdata_q.size() - wb), 32'd16);
        for (int k = 0; k < 16; k++) begin
            check("full_addr", 32'(waddr_q[wb+k]), 32'(k));
            check("full_data", 32'(wdata_q[wb+k]), 32'(k));
        end
        check("full_done", 32'(n_done - db), 32'd1);
        check("full_err", 32'(n_errp - eb), 32'd0);

        // Length 17 is one past capacity and must be rejected without writes.
        wb = wdata_q.size(); db = n_done; eb = n_errp;
        pulse_start();
        send_byte(8'h11, 1'b0);
        in_valid = 1'b0;
        wait_end("big");
        check("big_err", 32'(n_errp - eb), 32'd1);
        check("big_done", 32'(n_done - db), 32'd0);
        check("big_nwr", 32'(wdata_q.size() - wb), 32'd0);
        check("big_halt", 32'(cpu_halt), 32'd0);
        tick();
        check("big_err_clr", 32'(error), 32'd0);

        // A start pulse mid-load must not restart the address counter.
        wb = wdata_q.size(); db = n_done;
        pay = '{8'h5A, 8'h6B, 8'h7C};
        pulse_start();
        send_byte(8'h03, 1'b0);
        send_byte(8'h5A, 1'b0);
        in_valid = 1'b0;
        pulse_start();
        send_byte(8'h6B, 1'b0);
        send_byte(8'h7C, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(sum8(), 1'b0);
`endif
        in_valid = 1'b0;
        wait_end("busy_start");
        check("bs_nwr", 32'(wdata_q.size() - wb), 32'd3);
        check("bs_a2", 32'(waddr_q[wb+2]), 32'h2);
        check("bs_d2", 32'(wdata_q[wb+2]), 32'h7C);
        check("bs_done", 32'(n_done - db), 32'd1);

        // Five-byte load with random idle gaps from the host.
        wb = wdata_q.size(); db = n_done;
        pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        pulse_start();
        send_load(8'h05, 1'b1);
        wait_end("gaps");
        check("gaps_nwr", 32'(wdata_q.size() - wb), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("gaps_addr", 32'(waddr_q[wb+k]), 32'(k));
            check("gaps_data", 32'(wdata_q[wb+k]), 32'(8'h11 * (k + 1)));
        end
        check("gaps_done", 32'(n_done - db), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // 10 + 20 = 30: good checksum completes, bad checksum rejects after writing.
        wb = wdata_q.size(); db = n_done; eb = n_errp;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        in_valid = 1'b0;
        wait_end("cs_ok");
        check("cs_ok_done", 32'(n_done - db), 32'd1);
        check("cs_ok_err", 32'(n_errp - eb), 32'd0);
        wb = wdata_q.size(); db = n_done; eb = n_errp;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h31, 1'b0);
        in_valid = 1'b0;
        wait_end("cs_bad");
        check("cs_bad_err", 32'(n_errp - eb), 32'd1);
        check("cs_bad_done", 32'(n_done - db), 32'd0);
        check("cs_bad_nwr", 32'(wdata_q.size() - wb), 32'd2);
`endif

        check("never_done_and_err", 32'(n_both), 32'd0);
        check("busy_eq_halt", 32'(n_halt_bad), 32'd0);
        check("no_ready_in_write", 32'(n_rdy_wr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
